// File: rtl/dnpcie_aurora_rx_frame_buffer.sv
`timescale 1ns/1ps
// Store-and-forward Aurora RX buffer: frames are committed only when they end clean.
// Define AURORA_RX_FRAME_STATS_EN to add saturating frame statistics counters.
module dnpcie_aurora_rx_frame_buffer #(
`ifdef AURORA_RX_FRAME_STATS_EN
   parameter int ADDR_WIDTH = 9,
   parameter int CNT_WIDTH  = 16
`else
   parameter int ADDR_WIDTH = 9
`endif
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  channel_up,
   input  logic [0:31]           s_axis_tdata,
   input  logic [0:3]            s_axis_tkeep,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tuser,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_crc_pass_fail_n,
   input  logic                  s_axis_crc_valid,
   input  logic                  s_axis_length_err,
   output logic [0:31]           m_axis_tdata,
   output logic [0:3]            m_axis_tkeep,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready,
   output logic                  frame_dropped,
   output logic                  overflow,
`ifdef AURORA_RX_FRAME_STATS_EN
   output logic [CNT_WIDTH-1:0]  frames_ok_count,
   output logic [CNT_WIDTH-1:0]  frames_crc_err_count,
   output logic [CNT_WIDTH-1:0]  frames_overflow_count,
`endif
   output logic [ADDR_WIDTH-1:0] frames_pending
);

   localparam int WORD_W = 37;
   localparam int DEPTH  = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {
      WR_IDLE,
      WR_FRAME,
      WR_DISCARD
   } wr_state_e;

   wr_state_e             wr_state_q, wr_state_d;
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] commit_ptr_q, commit_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH-1:0] wr_ptr_inc;
   logic [ADDR_WIDTH-1:0] frames_pending_q, frames_pending_d;
   logic                  err_q, err_d;
   logic                  frame_dropped_q, frame_dropped_d;
   logic                  overflow_q, overflow_d;
   logic                  s1_valid_q, s1_valid_d;
   logic                  m_valid_q, m_valid_d;
   logic [WORD_W-1:0]     m_word_q, m_word_d;
   logic [WORD_W-1:0]     rd_word_q;
   logic [WORD_W-1:0]     ram_q [DEPTH];

   logic ram_we;
   logic rd_en;
   logic out_ready;
   logic last_hs;
   logic full;
   logic frame_ok;
   logic commit;
   logic drop_bad;
   logic drop_ovf;

   assign wr_ptr_inc = wr_ptr_q + 1'b1;
   assign full       = (wr_ptr_inc == rd_ptr_q);
   assign frame_ok   = s_axis_crc_valid && s_axis_crc_pass_fail_n && !s_axis_length_err
                       && !s_axis_tuser && !err_q;

   always_comb begin
      wr_state_d   = wr_state_q;
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      err_d        = err_q;
      ram_we       = 1'b0;
      commit       = 1'b0;
      drop_bad     = 1'b0;
      drop_ovf     = 1'b0;
      case (wr_state_q)
         WR_IDLE, WR_FRAME: begin
            if (!channel_up) begin
               if (wr_state_q == WR_FRAME) begin
                  wr_ptr_d   = commit_ptr_q;
                  err_d      = 1'b0;
                  drop_bad   = 1'b1;
                  wr_state_d = WR_IDLE;
               end
            end else if (s_axis_tvalid) begin
               if (full) begin
                  drop_ovf   = 1'b1;
                  wr_ptr_d   = commit_ptr_q;
                  err_d      = 1'b0;
                  wr_state_d = s_axis_tlast ? WR_IDLE : WR_DISCARD;
               end else begin
                  ram_we   = 1'b1;
                  wr_ptr_d = wr_ptr_inc;
                  if (s_axis_tlast) begin
                     err_d      = 1'b0;
                     wr_state_d = WR_IDLE;
                     if (frame_ok) begin
                        commit       = 1'b1;
                        commit_ptr_d = wr_ptr_inc;
                     end else begin
                        drop_bad = 1'b1;
                        wr_ptr_d = commit_ptr_q;
                     end
                  end else begin
                     err_d      = err_q | s_axis_tuser;
                     wr_state_d = WR_FRAME;
                  end
               end
            end
         end
         // The frame was already reported as dropped; a link loss just ends the discard.
         WR_DISCARD: begin
            if (!channel_up || (s_axis_tvalid && s_axis_tlast)) begin
               wr_state_d = WR_IDLE;
            end
         end
         default: wr_state_d = WR_IDLE;
      endcase
      frame_dropped_d = drop_bad | drop_ovf;
      overflow_d      = drop_ovf;
   end

   // Two-stage read pipeline: RAM output register feeding the AXI4-Stream output register.
   always_comb begin
      out_ready  = !m_valid_q || m_axis_tready;
      rd_en      = (rd_ptr_q != commit_ptr_q) && (!s1_valid_q || out_ready);
      rd_ptr_d   = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
      s1_valid_d = rd_en || (s1_valid_q && !out_ready);
      m_valid_d  = m_valid_q;
      m_word_d   = m_word_q;
      if (out_ready) begin
         m_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            m_word_d = rd_word_q;
         end
      end
      last_hs          = m_valid_q && m_axis_tready && m_word_q[0];
      frames_pending_d = frames_pending_q;
      if (commit && !last_hs) begin
         frames_pending_d = frames_pending_q + 1'b1;
      end else if (!commit && last_hs) begin
         frames_pending_d = frames_pending_q - 1'b1;
      end
   end

   always_ff @(posedge aclk) begin
      if (ram_we) begin
         ram_q[wr_ptr_q] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
      end
      if (rd_en) begin
         rd_word_q <= ram_q[rd_ptr_q];
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_state_q       <= WR_IDLE;
         wr_ptr_q         <= '0;
         commit_ptr_q     <= '0;
         rd_ptr_q         <= '0;
         err_q            <= 1'b0;
         frame_dropped_q  <= 1'b0;
         overflow_q       <= 1'b0;
         s1_valid_q       <= 1'b0;
         m_valid_q        <= 1'b0;
         m_word_q         <= '0;
         frames_pending_q <= '0;
      end else begin
         wr_state_q       <= wr_state_d;
         wr_ptr_q         <= wr_ptr_d;
         commit_ptr_q     <= commit_ptr_d;
         rd_ptr_q         <= rd_ptr_d;
         err_q            <= err_d;
         frame_dropped_q  <= frame_dropped_d;
         overflow_q       <= overflow_d;
         s1_valid_q       <= s1_valid_d;
         m_valid_q        <= m_valid_d;
         m_word_q         <= m_word_d;
         frames_pending_q <= frames_pending_d;
      end
   end

   assign m_axis_tdata   = m_word_q[36:5];
   assign m_axis_tkeep   = m_word_q[4:1];
   assign m_axis_tlast   = m_word_q[0];
   assign m_axis_tvalid  = m_valid_q;
   assign frame_dropped  = frame_dropped_q;
   assign overflow       = overflow_q;
   assign frames_pending = frames_pending_q;

`ifdef AURORA_RX_FRAME_STATS_EN
   logic [CNT_WIDTH-1:0] ok_cnt_q, ok_cnt_d;
   logic [CNT_WIDTH-1:0] crc_cnt_q, crc_cnt_d;
   logic [CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;

   // Counters stick at all-ones instead of wrapping.
   always_comb begin
      ok_cnt_d  = ok_cnt_q;
      crc_cnt_d = crc_cnt_q;
      ovf_cnt_d = ovf_cnt_q;
      if (commit && (ok_cnt_q != '1)) begin
         ok_cnt_d = ok_cnt_q + 1'b1;
      end
      if (drop_bad && (crc_cnt_q != '1)) begin
         crc_cnt_d = crc_cnt_q + 1'b1;
      end
      if (drop_ovf && (ovf_cnt_q != '1)) begin
         ovf_cnt_d = ovf_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         ok_cnt_q  <= '0;
         crc_cnt_q <= '0;
         ovf_cnt_q <= '0;
      end else begin
         ok_cnt_q  <= ok_cnt_d;
         crc_cnt_q <= crc_cnt_d;
         ovf_cnt_q <= ovf_cnt_d;
      end
   end

   assign frames_ok_count       = ok_cnt_q;
   assign frames_crc_err_count  = crc_cnt_q;
   assign frames_overflow_count = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_dnpcie_aurora_rx_frame_buffer.sv
`timescale 1ns/1ps
// Directed bench for dnpcie_aurora_rx_frame_buffer built with a 16-word buffer:
// cycle-by-cycle vector table plus hand-written overflow, link-loss and reset sequences.
module tb_dnpcie_aurora_rx_frame_buffer;

   localparam int AW = 4;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic          channelUp;
   logic [0:31]   sTdata;
   logic [0:3]    sTkeep;
   logic          sTvalid;
   logic          sTuser;
   logic          sTlast;
   logic          sCrcPass;
   logic          sCrcValid;
   logic          sLenErr;
   logic [0:31]   mTdata;
   logic [0:3]    mTkeep;
   logic          mTvalid;
   logic          mTlast;
   logic          mTready;
   logic          frameDropped;
   logic          overflow;
   logic [AW-1:0] framesPending;
`ifdef AURORA_RX_FRAME_STATS_EN
   logic [15:0]   okCount;
   logic [15:0]   crcErrCount;
   logic [15:0]   ovfCount;
`endif

   int testCount = 0;
   int failCount = 0;

   dnpcie_aurora_rx_frame_buffer #(
      .ADDR_WIDTH(AW)
   ) dut (
      .aclk                  (aclk),
      .aresetn               (aresetn),
      .channel_up            (channelUp),
      .s_axis_tdata          (sTdata),
      .s_axis_tkeep          (sTkeep),
      .s_axis_tvalid         (sTvalid),
      .s_axis_tuser          (sTuser),
      .s_axis_tlast          (sTlast),
      .s_axis_crc_pass_fail_n(sCrcPass),
      .s_axis_crc_valid      (sCrcValid),
      .s_axis_length_err     (sLenErr),
      .m_axis_tdata          (mTdata),
      .m_axis_tkeep          (mTkeep),
      .m_axis_tvalid         (mTvalid),
      .m_axis_tlast          (mTlast),
      .m_axis_tready         (mTready),
      .frame_dropped         (frameDropped),
      .overflow              (overflow),
`ifdef AURORA_RX_FRAME_STATS_EN
      .frames_ok_count       (okCount),
      .frames_crc_err_count  (crcErrCount),
      .frames_overflow_count (ovfCount),
`endif
      .frames_pending        (framesPending)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic        valid;
      logic [0:31] data;
      logic [0:3]  keep;
      logic        last;
      logic        user;
      logic        crcValid;
      logic        crcPass;
      logic        lenErr;
      logic        ready;
      logic        expValid;
      logic [0:31] expData;
      logic [0:3]  expKeep;
      logic        expLast;
      logic        expDropped;
      logic        expOverflow;
      int          expPending;
      int          expWrPtr;
   } vector_t;

   typedef struct {
      logic [0:31] data;
      logic [0:3]  keep;
      logic        last;
   } beat_t;

   vector_t vecs[$];
   beat_t   expQ[$];

   function automatic vector_t vec(
      input logic v, input logic [0:31] d, input logic [0:3] k, input logic l,
      input logic u, input logic cv, input logic cp, input logic le, input logic r,
      input logic ev, input logic [0:31] ed, input logic [0:3] ek, input logic el,
      input logic edrop, input logic eovf, input int epend, input int ewr);
      vector_t t;
      t.valid = v;  t.data = d;  t.keep = k;  t.last = l;  t.user = u;
      t.crcValid = cv;  t.crcPass = cp;  t.lenErr = le;  t.ready = r;
      t.expValid = ev;  t.expData = ed;  t.expKeep = ek;  t.expLast = el;
      t.expDropped = edrop;  t.expOverflow = eovf;  t.expPending = epend;  t.expWrPtr = ewr;
      return t;
   endfunction

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic checkEq(input string name, input logic [39:0] act, input logic [39:0] exp);
      testCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vector_t v);
      sTvalid   = v.valid;
      sTdata    = v.data;
      sTkeep    = v.keep;
      sTlast    = v.last;
      sTuser    = v.user;
      sCrcValid = v.crcValid;
      sCrcPass  = v.crcPass;
      sLenErr   = v.lenErr;
      mTready   = v.ready;
      tick();
   endtask

   task automatic checkOutput(input int idx, input vector_t v);
      logic ok;
      ok = (mTvalid === v.expValid) && (frameDropped === v.expDropped)
           && (overflow === v.expOverflow) && (int'(framesPending) == v.expPending);
      if (v.expValid) begin
         ok &= (mTdata === v.expData) && (mTkeep === v.expKeep) && (mTlast === v.expLast);
      end
      if (v.expWrPtr >= 0) begin
         ok &= (int'(dut.wr_ptr_q) == v.expWrPtr);
      end
      testCount++;
      if (!ok) begin
         failCount++;
         $display("[TB] FAIL vec%0d: got valid=%b data=%h keep=%h last=%b drop=%b ovf=%b pend=%0d wr=%0d, expected valid=%b data=%h keep=%h last=%b drop=%b ovf=%b pend=%0d wr=%0d",
                  idx, mTvalid, mTdata, mTkeep, mTlast, frameDropped, overflow, framesPending,
                  dut.wr_ptr_q, v.expValid, v.expData, v.expKeep, v.expLast, v.expDropped,
                  v.expOverflow, v.expPending, v.expWrPtr);
      end
   endtask

   task automatic sendBeat(input logic [0:31] data, input logic last, input logic good);
      sTvalid   = 1'b1;
      sTdata    = data;
      sTkeep    = 4'hF;
      sTlast    = last;
      sTuser    = 1'b0;
      sCrcValid = last;
      sCrcPass  = good;
      sLenErr   = 1'b0;
      tick();
      sTvalid   = 1'b0;
      sTlast    = 1'b0;
      sCrcValid = 1'b0;
      sCrcPass  = 1'b0;
   endtask

   task automatic expectBeat(input logic [0:31] data, input logic last);
      beat_t b;
      b.data = data;
      b.keep = 4'hF;
      b.last = last;
      expQ.push_back(b);
   endtask

   // Each beat seen valid with tready high is accepted on the following edge.
   task automatic drainExpected(input string name);
      int got = 0;
      int budget = 0;
      int n = expQ.size();
      mTready = 1'b1;
      while (got < n && budget < 50) begin
         if (mTvalid) begin
            testCount++;
            if (mTdata !== expQ[got].data || mTkeep !== expQ[got].keep || mTlast !== expQ[got].last) begin
               failCount++;
               $display("[TB] FAIL %s beat%0d: got data=%h keep=%h last=%b, expected data=%h keep=%h last=%b",
                        name, got, mTdata, mTkeep, mTlast, expQ[got].data, expQ[got].keep, expQ[got].last);
            end
            got++;
         end
         tick();
         budget++;
      end
      testCount++;
      if (got != n) begin
         failCount++;
         $display("[TB] FAIL %s timeout: got %0d beats, expected %0d", name, got, n);
      end
      expQ.delete();
   endtask

   task automatic expectQuiet(input string name, input int cycles);
      int seen = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (mTvalid) seen++;
      end
      checkEq(name, 40'(seen), 40'd0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int dropSeen;
      int ovfSeen;
      int waitCnt;

      aresetn   = 1'b0;
      channelUp = 1'b1;
      sTvalid   = 1'b0;
      sTdata    = '0;
      sTkeep    = '0;
      sTlast    = 1'b0;
      sTuser    = 1'b0;
      sCrcValid = 1'b0;
      sCrcPass  = 1'b0;
      sLenErr   = 1'b0;
      mTready   = 1'b0;
      tick();
      tick();
      aresetn = 1'b1;
      tick();

      checkEq("reset_valid", 40'(mTvalid), 40'd0);
      checkEq("reset_pending", 40'(framesPending), 40'd0);
      checkEq("reset_data", 40'({mTdata, mTkeep, mTlast}), 40'd0);
      checkEq("reset_pulses", 40'({frameDropped, overflow}), 40'd0);

      // 4-beat good frame: output valid two edges after the tlast edge
      vecs.push_back(vec(1, 32'h00010203, 4'hF, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 1));
      vecs.push_back(vec(1, 32'h04050607, 4'hF, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 2));
      vecs.push_back(vec(1, 32'h08090A0B, 4'hF, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 3));
      vecs.push_back(vec(1, 32'h0C0D0E0F, 4'hF, 1, 0, 1, 1, 0, 1,  0, 0, 0, 0, 0, 0, 1, 4));
      vecs.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 1, -1));
      vecs.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 32'h00010203, 4'hF, 0, 0, 0, 1, -1));
      vecs.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 32'h04050607, 4'hF, 0, 0, 0, 1, -1));
      vecs.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 32'h08090A0B, 4'hF, 0, 0, 0, 1, -1));
      vecs.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 32'h0C0D0E0F, 4'hF, 1, 0, 0, 1, -1));
      vecs.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, -1));
      // bad-CRC 3-beat frame rewound, then good 2-beat frame reuses the space
      vecs.push_back(vec(1, 32'h11111111, 4'hF, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 5));
      vecs.push_back(vec(1, 32'h22222222, 4'hF, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 6));
      vecs.push_back(vec(1, 32'h33333333, 4'hF, 1, 0, 1, 0, 0, 1,  0, 0, 0, 0, 1, 0, 0, 4));
      vecs.push_back(vec(1, 32'hAAAA0001, 4'hF, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 5));
      vecs.push_back(vec(1, 32'hAAAA0002, 4'hF, 1, 0, 1, 1, 0, 1,  0, 0, 0, 0, 0, 0, 1, 6));
      vecs.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 1, -1));
      vecs.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 32'hAAAA0001, 4'hF, 0, 0, 0, 1, -1));
      vecs.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 32'hAAAA0002, 4'hF, 1, 0, 0, 1, -1));
      vecs.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, -1));
      // two single-beat tkeep=C frames held stable under toggling tready
      vecs.push_back(vec(1, 32'hDEADBEEF, 4'hC, 1, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 7));
      vecs.push_back(vec(1, 32'hCAFEF00D, 4'hC, 1, 0, 1, 1, 0, 1,  0, 0, 0, 0, 0, 0, 2, 8));
      vecs.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 32'hDEADBEEF, 4'hC, 1, 0, 0, 2, -1));
      vecs.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 32'hDEADBEEF, 4'hC, 1, 0, 0, 2, -1));
      vecs.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 32'hCAFEF00D, 4'hC, 1, 0, 0, 1, -1));
      vecs.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 32'hCAFEF00D, 4'hC, 1, 0, 0, 1, -1));
      vecs.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, -1));
      // length error, tuser mid-frame, and missing crc_valid all drop the frame
      vecs.push_back(vec(1, 32'h12345678, 4'hF, 1, 0, 1, 1, 1, 1,  0, 0, 0, 0, 1, 0, 0, 8));
      vecs.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 8));
      vecs.push_back(vec(1, 32'h55555555, 4'hF, 0, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 9));
      vecs.push_back(vec(1, 32'h66666666, 4'hF, 1, 0, 1, 1, 0, 1,  0, 0, 0, 0, 1, 0, 0, 8));
      vecs.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, -1));
      vecs.push_back(vec(1, 32'h77777777, 4'hF, 1, 0, 0, 1, 0, 1,  0, 0, 0, 0, 1, 0, 0, 8));
      vecs.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 8));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput(i, vecs[i]);
      end
      sTvalid = 1'b0;
      sTlast  = 1'b0;
      sCrcValid = 1'b0;
      sCrcPass  = 1'b0;
      sLenErr   = 1'b0;
      sTuser    = 1'b0;

      $display("[TB] overflow: 20-beat frame into a 15-word buffer");
      mTready = 1'b0;
      ovfSeen = 0;
      for (int i = 0; i < 20; i++) begin
         sendBeat(32'hF0000000 | 32'(i), i == 19, 1'b1);
         checkEq($sformatf("ovf_beat%0d", i + 1), 40'({overflow, frameDropped}),
                 (i == 15) ? 40'd3 : 40'd0);
      end
      tick();
      checkEq("ovf_pending", 40'(framesPending), 40'd0);
      checkEq("ovf_wrptr", 40'(dut.wr_ptr_q), 40'd8);
      sendBeat(32'hB0000001, 1'b0, 1'b1);
      sendBeat(32'hB0000002, 1'b0, 1'b1);
      sendBeat(32'hB0000003, 1'b1, 1'b1);
      checkEq("ovf_after_pulse", 40'({overflow, frameDropped}), 40'd0);
      tick();
      tick();
      checkEq("ovf_next_pending", 40'(framesPending), 40'd1);
      expectBeat(32'hB0000001, 1'b0);
      expectBeat(32'hB0000002, 1'b0);
      expectBeat(32'hB0000003, 1'b1);
      drainExpected("ovf_next_frame");
      checkEq("ovf_next_done", 40'(framesPending), 40'd0);

      $display("[TB] link loss mid-frame with a committed frame pending");
      mTready = 1'b0;
      sendBeat(32'hD0000001, 1'b0, 1'b1);
      sendBeat(32'hD0000002, 1'b1, 1'b1);
      sendBeat(32'hE0000001, 1'b0, 1'b1);
      sendBeat(32'hE0000002, 1'b0, 1'b1);
      channelUp = 1'b0;
      dropSeen  = 0;
      sendBeat(32'hE0000003, 1'b0, 1'b1);
      if (frameDropped) dropSeen++;
      sendBeat(32'hE0000004, 1'b1, 1'b1);
      if (frameDropped) dropSeen++;
      channelUp = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (frameDropped) dropSeen++;
      end
      checkEq("link_drop_count", 40'(dropSeen), 40'd1);
      checkEq("link_pending", 40'(framesPending), 40'd1);
      expectBeat(32'hD0000001, 1'b0);
      expectBeat(32'hD0000002, 1'b1);
      drainExpected("link_committed");
      checkEq("link_done_pending", 40'(framesPending), 40'd0);
      expectQuiet("link_no_extra", 4);

      $display("[TB] reset while output is active");
      mTready = 1'b0;
      sendBeat(32'hF1000001, 1'b0, 1'b1);
      sendBeat(32'hF1000002, 1'b0, 1'b1);
      sendBeat(32'hF1000003, 1'b1, 1'b1);
      waitCnt = 0;
      while (!mTvalid && waitCnt < 10) begin
         tick();
         waitCnt++;
      end
      checkEq("rst_pre_valid", 40'({mTvalid, mTdata}), {8'h01, 32'hF1000001});
      mTready = 1'b1;
      tick();
      mTready = 1'b0;
      checkEq("rst_pre_pending", 40'(framesPending), 40'd1);
      #2;
      aresetn = 1'b0;
      #1;
      checkEq("rst_async_valid", 40'(mTvalid), 40'd0);
      checkEq("rst_async_pending", 40'(framesPending), 40'd0);
      checkEq("rst_async_data", 40'({mTdata, mTkeep, mTlast}), 40'd0);
      tick();
      tick();
      aresetn = 1'b1;
      tick();
      sendBeat(32'h9A000001, 1'b0, 1'b1);
      sendBeat(32'h9A000002, 1'b1, 1'b1);
      tick();
      tick();
      checkEq("rst_after_pending", 40'(framesPending), 40'd1);
      expectBeat(32'h9A000001, 1'b0);
      expectBeat(32'h9A000002, 1'b1);
      drainExpected("rst_after_frame");
      expectQuiet("rst_no_stale", 4);
      checkEq("rst_final_pending", 40'(framesPending), 40'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
